// File: rtl/kbd_pkg.sv
// kbd_pkg: scancode constants, decoder FSM states, flag positions and Set-2 to ASCII lookup.
package kbd_pkg;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_NUL    = 8'h00;
    localparam logic [7:0] SC_ERR    = 8'hFF;
    localparam int F_BRK   = 7;
    localparam int F_EXT   = 6;
    localparam int F_SHIFT = 5;
    localparam int F_CTRL  = 4;
    localparam int F_CAPS  = 3;
    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;
    typedef logic [23:0] event_t;
    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
        logic [7:0] c;
        case (code)
            8'h1C: c = 8'h61; 8'h32: c = 8'h62; 8'h21: c = 8'h63; 8'h23: c = 8'h64;
            8'h24: c = 8'h65; 8'h2B: c = 8'h66; 8'h34: c = 8'h67; 8'h33: c = 8'h68;
            8'h43: c = 8'h69; 8'h3B: c = 8'h6A; 8'h42: c = 8'h6B; 8'h4B: c = 8'h6C;
            8'h3A: c = 8'h6D; 8'h31: c = 8'h6E; 8'h44: c = 8'h6F; 8'h4D: c = 8'h70;
            8'h15: c = 8'h71; 8'h2D: c = 8'h72; 8'h1B: c = 8'h73; 8'h2C: c = 8'h74;
            8'h3C: c = 8'h75; 8'h2A: c = 8'h76; 8'h1D: c = 8'h77; 8'h22: c = 8'h78;
            8'h35: c = 8'h79; 8'h1A: c = 8'h7A;
            8'h45: c = 8'h30; 8'h16: c = 8'h31; 8'h1E: c = 8'h32; 8'h26: c = 8'h33;
            8'h25: c = 8'h34; 8'h2E: c = 8'h35; 8'h36: c = 8'h36; 8'h3D: c = 8'h37;
            8'h3E: c = 8'h38; 8'h46: c = 8'h39;
            8'h29: c = 8'h20; 8'h5A: c = 8'h0D; 8'h66: c = 8'h08; 8'h76: c = 8'h1B;
            default: c = 8'h00;
        endcase
        return (upper && c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction
endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: synchronous FIFO with async reset; push and pop may coincide even when full.
module kbd_event_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;
    assign full    = count == (PTR_W+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: folds Set-2 E0/F0 prefixes into key events with modifiers and ASCII, queued for a bus reader.
// KBD_REPEAT_FILTER_EN drops typematic repeats of the most recent make.
module ps2_key_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic        clk_read,
    input  logic        reset,
    input  logic [7:0]  scan_data,
    input  logic        scan_ready,
    output logic        scan_rdn,
    input  logic        STB,
    input  logic        WE,
    output logic        ACK,
    output logic [31:0] key_data,
    output logic        INT
);
    state_t     state, state_d;
    logic [7:0] byte_q, flags, ascii;
    logic       ext_f, brk_f, lshift, rshift, ctrl, caps_lock, caps_held, stb_d;
    logic       lshift_d, rshift_d, ctrl_d, caps_lock_d, caps_held_d, caps_hit, shift_d;
    logic       take, dec, is_ext, is_brk, junk, key, push, pop, full, empty;
    event_t     head;
`ifdef KBD_REPEAT_FILTER_EN
    logic [8:0] last_make, last_make_d;
`endif
    always_comb begin
        take        = state == IDLE && scan_ready && !full;
        state_d     = state == IDLE ? (take ? POP : IDLE) : state == POP ? DECODE : IDLE;
        dec         = state == DECODE;
        is_ext      = byte_q == SC_EXT;
        is_brk      = byte_q == SC_BRK;
        junk        = byte_q == SC_BAT || byte_q == SC_NUL || byte_q == SC_ERR;
        key         = dec && !is_ext && !is_brk && !junk;
        lshift_d    = key && !ext_f && byte_q == SC_LSHIFT ? !brk_f : lshift;
        rshift_d    = key && !ext_f && byte_q == SC_RSHIFT ? !brk_f : rshift;
        ctrl_d      = key && byte_q == SC_CTRL ? !brk_f : ctrl;
        caps_hit    = key && !ext_f && byte_q == SC_CAPS;
        caps_held_d = caps_hit ? !brk_f : caps_held;
        caps_lock_d = caps_hit && !brk_f && !caps_held ? !caps_lock : caps_lock;
        shift_d     = lshift_d | rshift_d;
        flags          = '0;
        flags[F_BRK]   = brk_f;
        flags[F_EXT]   = ext_f;
        flags[F_SHIFT] = shift_d;
        flags[F_CTRL]  = ctrl_d;
        flags[F_CAPS]  = caps_lock_d;
        ascii = ext_f ? 8'h00 : ascii_of(byte_q, shift_d ^ caps_lock_d);
`ifdef KBD_REPEAT_FILTER_EN
        push        = key && (brk_f || {ext_f, byte_q} != last_make);
        last_make_d = !key ? last_make : !brk_f ? {ext_f, byte_q} :
                      {ext_f, byte_q} == last_make ? 9'd0 : last_make;
`else
        push = key;
`endif
    end
    assign pop      = STB && !WE && !stb_d;
    assign ACK      = STB;
    assign INT      = !empty;
    assign key_data = empty ? 32'd0 : {8'd0, head};
    always_ff @(posedge clk_read or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            byte_q    <= '0;
            scan_rdn  <= 1'b1;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            ctrl      <= 1'b0;
            caps_lock <= 1'b0;
            caps_held <= 1'b0;
            stb_d     <= 1'b0;
`ifdef KBD_REPEAT_FILTER_EN
            last_make <= '0;
`endif
        end else begin
            state     <= state_d;
            scan_rdn  <= !take;
            stb_d     <= STB;
            lshift    <= lshift_d;
            rshift    <= rshift_d;
            ctrl      <= ctrl_d;
            caps_lock <= caps_lock_d;
            caps_held <= caps_held_d;
            if (take) byte_q <= scan_data;
            // prefixes accumulate until a real key consumes them; junk bytes leave them alone
            if (dec && is_ext) ext_f <= 1'b1;
            else if (key) ext_f <= 1'b0;
            if (dec && is_brk) brk_f <= 1'b1;
            else if (key) brk_f <= 1'b0;
`ifdef KBD_REPEAT_FILTER_EN
            last_make <= last_make_d;
`endif
        end
    end
    kbd_event_fifo #(.WIDTH(24), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk   (clk_read),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   ({byte_q, flags, ascii}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 scancode receiver (the byte FIFO exposing data/ready/rdn).
- Pops raw Set-2 scancode bytes and folds E0/F0 prefixes into one key event.
- Tracks modifier state and translates printable keys to ASCII.
- Buffers events in a small FIFO, exposed to the CPU bus as a 32-bit word with an interrupt line.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk_read  in  1  system clock; same clock as the receiver read side.
- reset  in  1  asynchronous, active-high reset.
- scan_data  in  8  head byte of the receiver FIFO.
- scan_ready  in  1  receiver FIFO non-empty.
- scan_rdn  out  1  active-low pop to the receiver, one clk_read cycle per byte.
- STB  in  1  bus strobe.
- WE  in  1  bus write enable; writes are ignored.
- ACK  out  1  equals STB (combinational).
- key_data  out  32  {8'b0, raw[23:16], flags[15:8], ascii[7:0]} of the FIFO head; 0 when empty.
- INT  out  1  event FIFO non-empty.

Behaviour:
- Reset values: scan_rdn=1, INT=0, key_data=0; FIFO, prefix flags and modifiers cleared; state IDLE.
- Reset mid-operation aborts any partial prefix sequence.
- Flags byte:
  - [15] break
  - [14] extended
  - [13] shift (lshift|rshift)
  - [12] ctrl
  - [11] caps_lock
  - [10:8] 0
- FSM states: IDLE, POP, DECODE.
  - IDLE: if scan_ready && !fifo_full, capture scan_data into byte_q, scan_rdn<=0, go POP. If fifo_full, no pop (backpressure; the receiver's own buffer absorbs bytes).
  - POP: scan_rdn<=1, go DECODE. scan_rdn is low for exactly one cycle per byte.
  - DECODE: always returns to IDLE.
    - 0xE0: set ext_f, no push.
    - 0xF0: set brk_f, no push.
    - 0xAA, 0x00, 0xFF: discarded, flags unchanged.
    - Any other byte: update modifiers, push event {byte_q, flags, ascii}, then clear ext_f and brk_f.
- Latency: scan_ready sampled in cycle 0 -> INT high in cycle 3 (for a byte that is not a prefix).
- Modifiers:
  - 0x12 = lshift, 0x59 = rshift; set on make, clear on break.
  - 0x14 = ctrl, with or without E0.
  - 0x58 = caps: caps_lock toggles on make only when caps_held=0; caps_held set on make, cleared on break.
  - The flags pushed with a modifier event reflect the state after its update.
- ASCII translation (non-extended only; ascii=0 for extended, break-independent):
  - Letters a-z map to 0x61-0x7A; uppercase when shift^caps_lock.
  - Digits 0-9 map to 0x30-0x39, regardless of shift.
  - 0x29 -> 0x20, 0x5A -> 0x0D, 0x66 -> 0x08, 0x76 -> 0x1B.
  - Everything else -> 0.
- Bus read: pop the event FIFO on the first cycle of STB && !WE (rising-edge detect via stb_d register); holding STB pops once. key_data is combinational from the FIFO head.
- FIFO boundaries:
  - Push and pop in the same cycle: both occur, count unchanged; allowed when full.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push is never attempted when full, since IDLE blocks on fifo_full.

Optional Feature:
- Macro KBD_REPEAT_FILTER_EN.
- Defined: a 9-bit last_make register {ext,code} records the most recent make event. A make whose {ext,code} equals last_make is dropped (typematic repeat): modifiers are updated, nothing is pushed. A break whose {ext,code} matches last_make clears last_make to 0. Reset clears last_make.
- Not defined: every make is pushed, including typematic repeats.

Decomposition:
- Package kbd_pkg holds:
  - Scancode constants (SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS, SC_BAT=8'hAA).
  - FSM state enum.
  - Flag bit positions.
  - 24-bit event word typedef.
- Sub-module kbd_event_fifo: synchronous FIFO with async reset, parameterised width (24) and depth, ports push/pop/full/empty/head.
- The ASCII lookup is a function inside the package.

Test Plan:
1. Bytes 0x1C, then F0 1C; read twice -> key_data 0x001C0061, then 0x001C8061; INT falls after the second read.
2. 0x12, 0x1C, F0 12 -> the 0x1C event reads 0x001C2041 (shift flag set, 'A').
3. E0 75 -> key_data 0x00754000 (extended, ascii 0); E0 F0 75 -> 0x0075C000.
4. 0x58, F0 58, 0x15 -> 0x15 event = 0x00150851 ('Q', caps); a second 58/F0 58 pair clears caps_lock.
5. Push 6 make codes without reading (FIFO_DEPTH=4) -> scan_rdn pulses stop after the 4th event; one read resumes popping. Also assert reset mid-sequence (after E0) -> the next byte 0x1C yields 0x001C0061 with ext clear.
6. KBD_REPEAT_FILTER_EN defined: 1C 1C 1C F0 1C -> exactly two events (make, break). Undefined: four events.
